// File: rtl/char_pixel_serializer.sv
// Character glyph serializer: fetches 16 row bitmaps from an external
// character ROM and emits 128 pixels row-major, MSB-first, over valid/ready.
module char_pixel_serializer #(
  parameter bit INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] char_sel,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_data,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Pixel handshake: a pixel moves when pix_valid & pix_ready at a rising
  // edge; while pix_valid is high and pix_ready is low, pix_data/pix_eol/
  // pix_eof are held unchanged, and pix_valid never drops before transfer.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  char_q;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [7:0]  shreg;
  logic        last_col;
  logic        last_row;

  assign last_col = (col == 3'd7);
  assign last_row = (row == 4'd15);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      char_q <= 2'd0;
      row    <= 4'd0;
      col    <= 3'd0;
      shreg  <= 8'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            char_q <= char_sel;
            row    <= 4'd0;
          end
        end
        S_LOAD: begin
          shreg <= rom_data;
          col   <= 3'd0;
        end
        S_SHIFT: begin
          if (pix_ready) begin
            if (last_col) begin
              // Row stays at 15 after the final pixel so there is no second pass.
              if (!last_row) row <= row + 4'd1;
            end else begin
              shreg <= {shreg[6:0], 1'b0};
              col   <= col + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: begin
        if (pix_ready && last_col) state_nx = last_row ? S_DONE : S_LOAD;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Everything below decodes registered state only.
  assign rom_addr  = {char_q, row};
  assign busy      = (state != S_IDLE);
  assign pix_valid = (state == S_SHIFT);
  assign pix_data  = pix_valid & (shreg[7] ^ INVERT);
  assign pix_eol   = pix_valid & last_col;
  assign pix_eof   = pix_valid & last_col & last_row;
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_char_pixel_serializer.sv
// Bench for char_pixel_serializer: normal and reverse-video instances share
// stimulus; a ROM model feeds both and a scoreboard checks every pixel.
module tb_char_pixel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start;
  logic [1:0] char_sel;
  logic       pix_ready;

  logic [5:0] rom_addr0, rom_addr1;
  logic [7:0] rom_data0, rom_data1;
  logic       busy0, valid0, data0, eol0, eof0, done0;
  logic       busy1, valid1, data1, eol1, eof1, done1;
  logic [1:0] st0, st1;

  logic [7:0] rom_mem [64];
  assign rom_data0 = rom_mem[rom_addr0];
  assign rom_data1 = rom_mem[rom_addr1];

  char_pixel_serializer #(.INVERT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .char_sel(char_sel),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .busy(busy0),
    .pix_valid(valid0), .pix_ready(pix_ready), .pix_data(data0),
    .pix_eol(eol0), .pix_eof(eof0), .done(done0), .state_dbg(st0)
  );

  char_pixel_serializer #(.INVERT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .char_sel(char_sel),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1),
    .pix_valid(valid1), .pix_ready(pix_ready), .pix_data(data1),
    .pix_eol(eol1), .pix_eof(eof1), .done(done1), .state_dbg(st1)
  );

  // Glyphs "1".."4", bit 7 = leftmost pixel.
  logic [7:0] g0 [16] = '{8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18,
                          8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'hFF, 8'h00};
  logic [7:0] g1 [16] = '{8'h3C, 8'h66, 8'h06, 8'h06, 8'h0C, 8'h0C, 8'h18, 8'h18,
                          8'h30, 8'h30, 8'h60, 8'h60, 8'h60, 8'h66, 8'h7E, 8'h7F};
  logic [7:0] g2 [16] = '{8'hFF, 8'hFF, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h3C, 8'h7F,
                          8'h7F, 8'h03, 8'h03, 8'h03, 8'h83, 8'hC6, 8'hFF, 8'hFF};
  logic [7:0] g3 [16] = '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hCC, 8'hCC, 8'hFF,
                          8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C};

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  // {pix_data, pix_eol, pix_eof}
  logic [2:0] exp_q[$];
  logic [2:0] exp_inv_q[$];

  int   xfer_cnt, inv_xfer_cnt, done_cnt, done_cyc, inv_done_cyc;
  int   first_cyc, inv_first_cyc, eol_cnt, eol_err, eof_cnt, eof_idx;
  logic img [128];
  logic inv_img [128];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard: a transfer is decided by what is on the wires at the negedge
  // before the rising edge that takes it.
  always @(negedge clk) begin
    logic [2:0] e;
    if (valid0 && pix_ready) begin
      if (first_cyc < 0) first_cyc = edge_cnt - start_edge;
      if (xfer_cnt < 128) img[xfer_cnt] = data0;
      if (eol0) begin
        eol_cnt++;
        if (xfer_cnt % 8 != 7) eol_err++;
      end
      if (eof0) begin
        eof_cnt++;
        eof_idx = xfer_cnt;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_norm_extra: got pixel %0b with empty queue, required none", data0);
      end else begin
        e = exp_q.pop_front();
        if ({data0, eol0, eof0} !== e) begin
          failures++;
          $display("FAIL sb_norm_pix[%0d]: got %b required %b", xfer_cnt, {data0, eol0, eof0}, e);
        end
      end
      xfer_cnt++;
    end
    if (valid1 && pix_ready) begin
      if (inv_first_cyc < 0) inv_first_cyc = edge_cnt - start_edge;
      if (inv_xfer_cnt < 128) inv_img[inv_xfer_cnt] = data1;
      checks++;
      if (exp_inv_q.size() == 0) begin
        failures++;
        $display("FAIL sb_inv_extra: got pixel %0b with empty queue, required none", data1);
      end else begin
        e = exp_inv_q.pop_front();
        if ({data1, eol1, eof1} !== e) begin
          failures++;
          $display("FAIL sb_inv_pix[%0d]: got %b required %b", inv_xfer_cnt, {data1, eol1, eof1}, e);
        end
      end
      inv_xfer_cnt++;
    end
    if (done0) begin
      done_cnt++;
      done_cyc = edge_cnt - start_edge;
    end
    if (done1) inv_done_cyc = edge_cnt - start_edge;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_cyc();
    return edge_cnt - start_edge;
  endfunction

  function automatic logic [7:0] row_byte(input int r, input bit inv);
    logic [7:0] v;
    for (int c = 0; c < 8; c++) v[7-c] = inv ? inv_img[r*8+c] : img[r*8+c];
    return v;
  endfunction

  task automatic start_glyph(input logic [1:0] c);
    logic [7:0] b;
    for (int r = 0; r < 16; r++) begin
      b = rom_mem[{c, r[3:0]}];
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back({b[7-k], k == 7, (k == 7) && (r == 15)});
        exp_inv_q.push_back({~b[7-k], k == 7, (k == 7) && (r == 15)});
      end
    end
    xfer_cnt = 0; inv_xfer_cnt = 0; done_cnt = 0; done_cyc = -1; inv_done_cyc = -1;
    first_cyc = -1; inv_first_cyc = -1; eol_cnt = 0; eol_err = 0; eof_cnt = 0; eof_idx = -1;
    char_sel = c;
    start = 1'b1;
    start_edge = edge_cnt;
    step();
    start = 1'b0;
    char_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; char_sel = 2'd2; pix_ready = 1'b1;
    step(); step();
    checks++;
    if ({busy0, valid0, data0, eol0, eof0, done0} !== 6'b0 || rom_addr0 !== 6'd0 || st0 !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b valid=%b data=%b eol=%b eof=%b done=%b addr=%h st=%0d, required all 0",
               busy0, valid0, data0, eol0, eof0, done0, rom_addr0, st0);
    end
    checks++;
    if (data1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_inv_outputs: got data=%b busy=%b, required 0 0", data1, busy1);
    end
    reset_n = 1'b1; start = 1'b0;
    step(); step();
    checks++;
    if (busy0 !== 1'b0 || st0 !== 2'd0) begin
      failures++;
      $display("FAIL reset_start_discard: got busy=%b st=%0d, required 0 0", busy0, st0);
    end
  endtask

  task automatic test_char0();
    pix_ready = 1'b1;
    start_glyph(2'd0);
    wait_done(400);
    checks++;
    if (first_cyc !== 2) begin
      failures++;
      $display("FAIL c0_first_valid: got cycle %0d required 2", first_cyc);
    end
    checks++;
    if (done_cyc !== 145 || done_cnt !== 1) begin
      failures++;
      $display("FAIL c0_done: got cycle %0d count %0d required 145 1", done_cyc, done_cnt);
    end
    checks++;
    if (cur_cyc() !== 146 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL c0_idle: got cycle %0d busy %b required 146 0", cur_cyc(), busy0);
    end
    checks++;
    if (xfer_cnt !== 128 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL c0_xfers: got %0d left %0d required 128 0", xfer_cnt, exp_q.size());
    end
    checks++;
    if (row_byte(0, 0) !== 8'h18 || row_byte(14, 0) !== 8'hFF) begin
      failures++;
      $display("FAIL c0_rows: got row0 %h row14 %h required 18 ff", row_byte(0, 0), row_byte(14, 0));
    end
  endtask

  task automatic test_invert();
    pix_ready = 1'b1;
    start_glyph(2'd0);
    wait_done(400);
    checks++;
    if (row_byte(0, 1) !== 8'hE7 || row_byte(14, 1) !== 8'h00) begin
      failures++;
      $display("FAIL inv_rows: got row0 %h row14 %h required e7 00", row_byte(0, 1), row_byte(14, 1));
    end
    checks++;
    if (inv_first_cyc !== 2 || inv_done_cyc !== 145 || inv_xfer_cnt !== 128) begin
      failures++;
      $display("FAIL inv_timing: got first %0d done %0d xfers %0d required 2 145 128",
               inv_first_cyc, inv_done_cyc, inv_xfer_cnt);
    end
  endtask

  task automatic test_random_ready();
    int n = 0;
    start_glyph(2'd2);
    while (done_cnt == 0 && n < 2000) begin
      pix_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    pix_ready = 1'b1;
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL rnd_done: got %0d done pulses required 1", done_cnt);
    end
    checks++;
    if (row_byte(0, 0) !== 8'hFF || row_byte(1, 0) !== 8'hFF || row_byte(14, 0) !== 8'hFF ||
        row_byte(15, 0) !== 8'hFF || row_byte(7, 0) !== 8'h7F || row_byte(8, 0) !== 8'h7F) begin
      failures++;
      $display("FAIL rnd_rows: got %h %h %h %h %h %h required ff ff ff ff 7f 7f", row_byte(0, 0),
               row_byte(1, 0), row_byte(14, 0), row_byte(15, 0), row_byte(7, 0), row_byte(8, 0));
    end
    checks++;
    if (eol_cnt !== 16 || eol_err !== 0 || eof_cnt !== 1 || eof_idx !== 127 || xfer_cnt !== 128) begin
      failures++;
      $display("FAIL rnd_markers: got eol %0d bad %0d eof %0d at %0d xfers %0d required 16 0 1 127 128",
               eol_cnt, eol_err, eof_cnt, eof_idx, xfer_cnt);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    pix_ready = 1'b1;
    start_glyph(2'd3);
    while (xfer_cnt < 59 && n < 400) begin
      step();
      n++;
    end
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b1 || data0 !== 1'b1 || eol0 !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%b eol=%b required 1 1 0", k, valid0, data0, eol0);
      end
      step();
    end
    pix_ready = 1'b1;
    wait_done(400);
    checks++;
    if (done_cyc !== 150 || row_byte(7, 0) !== 8'hFF || xfer_cnt !== 128) begin
      failures++;
      $display("FAIL stall_result: got done %0d row7 %h xfers %0d required 150 ff 128",
               done_cyc, row_byte(7, 0), xfer_cnt);
    end
  endtask

  task automatic test_busy_start();
    int n = 0;
    pix_ready = 1'b1;
    start_glyph(2'd0);
    while (cur_cyc() < 40) step();
    start = 1'b1; char_sel = 2'd1;
    step(); step(); step();
    start = 1'b0;
    while (cur_cyc() < 145 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (done0 !== 1'b1) begin
      failures++;
      $display("FAIL busy_done_cycle: got done=%b at cycle %0d required 1 at 145", done0, cur_cyc());
    end
    start = 1'b1; char_sel = 2'd1;
    step();
    start = 1'b0;
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_in_done: got busy=%b required 0", busy0);
    end
    step();
    checks++;
    if (busy0 !== 1'b0 || done_cnt !== 1 || xfer_cnt !== 128 || row_byte(0, 0) !== 8'h18) begin
      failures++;
      $display("FAIL busy_ignore: got busy=%b done %0d xfers %0d row0 %h required 0 1 128 18",
               busy0, done_cnt, xfer_cnt, row_byte(0, 0));
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    int snap;
    pix_ready = 1'b1;
    start_glyph(2'd1);
    while (xfer_cnt < 77 && n < 400) begin
      step();
      n++;
    end
    reset_n = 1'b0; pix_ready = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if ({busy0, valid0, data0, eol0, eof0, done0} !== 6'b0 || rom_addr0 !== 6'd0 || st0 !== 2'd0) begin
      failures++;
      $display("FAIL abort_outputs: got busy=%b valid=%b data=%b eol=%b eof=%b done=%b addr=%h, required all 0",
               busy0, valid0, data0, eol0, eof0, done0, rom_addr0);
    end
    exp_q.delete();
    exp_inv_q.delete();
    snap = xfer_cnt;
    pix_ready = 1'b1;
    for (int k = 0; k < 20; k++) step();
    checks++;
    if (done_cnt !== 0 || xfer_cnt !== snap) begin
      failures++;
      $display("FAIL abort_quiet: got done %0d xfers %0d required 0 %0d", done_cnt, xfer_cnt, snap);
    end
    start_glyph(2'd1);
    wait_done(400);
    checks++;
    if (row_byte(0, 0) !== 8'h3C || row_byte(15, 0) !== 8'h7F || done_cyc !== 145 || xfer_cnt !== 128) begin
      failures++;
      $display("FAIL abort_restart: got row0 %h row15 %h done %0d xfers %0d required 3c 7f 145 128",
               row_byte(0, 0), row_byte(15, 0), done_cyc, xfer_cnt);
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      rom_mem[r]      = g0[r];
      rom_mem[16 + r] = g1[r];
      rom_mem[32 + r] = g2[r];
      rom_mem[48 + r] = g3[r];
    end
    reset_n = 1'b0; start = 1'b0; char_sel = 2'd0; pix_ready = 1'b0;
    xfer_cnt = 0; inv_xfer_cnt = 0; done_cnt = 0; done_cyc = -1; inv_done_cyc = -1;
    first_cyc = -1; inv_first_cyc = -1; eol_cnt = 0; eol_err = 0; eof_cnt = 0; eof_idx = -1;
    test_reset();
    test_char0();
    test_invert();
    test_random_ready();
    test_stall();
    test_busy_start();
    test_reset_abort();
    for (int k = 0; k < 3; k++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_pixel_serializer.md
CHAR_PIXEL_SERIALIZER -- requirements
Module: char_pixel_serializer

Interface
REQ-001 Parameter: INVERT, default 0, 1 = pix_data output is complemented (reverse video).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  input  1  request to render one glyph; sampled only in IDLE.
REQ-005 char_sel  input  2  glyph index (0..3 = "1".."4"); latched when start is accepted.
REQ-006 rom_addr  output  6  character ROM address = {char_q[1:0], row[3:0]}.
REQ-007 rom_data  input  8  row bitmap returned combinationally by char_rom for rom_addr; bit 7 = leftmost pixel.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 pix_valid  output  1  pixel on pix_data is valid.
REQ-010 pix_ready  input  1  downstream accepts pixel; transfer = pix_valid & pix_ready.
REQ-011 pix_data  output  1  current pixel (1 = lit, before INVERT).
REQ-012 pix_eol  output  1  high with pix_valid on column 7 of each row.
REQ-013 pix_eof  output  1  high with pix_valid on column 7 of row 15.
REQ-014 done  output  1  one-cycle pulse after the last pixel of a glyph transfers.

Function
REQ-015 FSM states: IDLE, LOAD, SHIFT, DONE; all outputs registered or decoded from registered state only.
REQ-016 IDLE: start=1 -> char_q<=char_sel, row<=0, next LOAD; start=0 -> stay IDLE.
REQ-017 start while busy is ignored; no queuing; char_sel changes while busy have no effect.
REQ-018 rom_addr is driven from char_q and row at all times; stable for the whole LOAD cycle.
REQ-019 LOAD: shreg<=rom_data, col<=0, next SHIFT; pix_valid=0 in LOAD.
REQ-020 SHIFT: pix_valid=1, pix_data=shreg[7] XOR INVERT.
REQ-021 SHIFT, no transfer: shreg, col, row, pix_data, pix_eol, pix_eof held unchanged.
REQ-022 SHIFT, transfer, col<7: shreg<=shreg<<1, col<=col+1, stay SHIFT.
REQ-023 SHIFT, transfer, col=7, row<15: row<=row+1, next LOAD.
REQ-024 SHIFT, transfer, col=7, row=15: next DONE; row does not wrap into a second pass.
REQ-025 DONE: done=1 for exactly one cycle, busy=1, next IDLE; start in DONE is ignored.
REQ-026 col is 3 bits, row is 4 bits; no arithmetic overflow occurs within a glyph.
REQ-027 Latency: start accepted in cycle 0 -> first pix_valid in cycle 2.
REQ-028 With pix_ready held 1: each row = 1 LOAD + 8 SHIFT cycles; last pixel in cycle 144; done in cycle 145; IDLE in cycle 146.
REQ-029 pix_ready low for k cycles at any point extends total time by exactly k cycles; pixel order unchanged.
REQ-030 Exactly 128 transfers per glyph, row-major, MSB-first within each row.

Reset
REQ-031 reset_n=0 at a rising edge -> state IDLE, busy=0, pix_valid=0, pix_data=0, pix_eol=0, pix_eof=0, done=0, rom_addr=0, char_q=0, row=0, col=0, shreg=0.
REQ-032 Reset in any state, including mid-row SHIFT and DONE, aborts immediately: no done pulse, no further pixels; next start behaves as from power-up.
REQ-033 start sampled high in the same cycle as reset_n=0 is discarded.

Verification
REQ-034 Connect char_rom as the ROM model; check every transfer against a golden bitmap.
REQ-035 char_sel=0, start pulse, pix_ready=1 -> row 0 pixels 0,0,0,1,1,0,0,0 (0x18) in cycles 2..9; row 14 = 8 ones; done in cycle 145; 128 transfers.
REQ-036 char_sel=2, pix_ready random ~50% -> rows 0,1,14,15 all ones; rows 7,8 = 0x7F; pix_eol on every 8th transfer; pix_eof only on transfer 128.
REQ-037 char_sel=3, pix_ready held 0 for 5 cycles at row 7 col 3 -> pix_data/pix_eol held stable; row 7 = 0xFF delivered intact; done in cycle 150.
REQ-038 start re-pulsed with char_sel=1 during rendering of char 0 -> ignored; full char 0 image output; one done pulse only.
REQ-039 reset_n=0 for one cycle at row 9 col 5 of char 1 -> next cycle all outputs at reset values; no done; subsequent start with char_sel=1 yields row 0 = 0x3C, row 15 = 0x7F.
REQ-040 INVERT=1, char_sel=0 -> row 0 pixels 1,1,1,0,0,1,1,1; row 14 = 8 zeros; timing identical to REQ-035.
